// File: rtl/i2c_slave_fsm.sv
// I2C target (slave) with 7-bit addressing, oversampled on the system clock.
// Ports:
//   clk, reset_n         system clock (>= 8x SCL), async active-low reset
//   scl_in, sda_in       raw I2C bus lines (sda_in is the resolved bus value)
//   sda_oe               1 = pull SDA low, 0 = release (open drain)
//   rx_data, rx_valid    last received write byte and its one-clk strobe
//   tx_data, tx_req      read byte from the host, requested by a one-clk pulse
//   busy, rw_dir         addressed-transfer flag and its R/W bit (1 = read)
module i2c_slave_fsm #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h55,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw_dir
);

    localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } state_e;

    logic [SYNC_W-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_W-1:0] sda_sync_q, sda_sync_d;
    logic              scl_prev_q, scl_prev_d;
    logic              sda_prev_q, sda_prev_d;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              sda_oe_q, sda_oe_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_req_q, tx_req_d;
    logic              busy_q, busy_d;
    logic              rw_dir_q, rw_dir_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Synchroniser chains and previous-sample registers for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_W-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_W-2:0], sda_in};
        scl_s      = scl_sync_q[SYNC_W-1];
        sda_s      = sda_sync_q[SYNC_W-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Bus events; START/STOP require SCL high on both samples.
    always_comb begin
        scl_rise  = scl_s & ~scl_prev_q;
        scl_fall  = ~scl_s & scl_prev_q;
        start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        rw_dir_d   = rw_dir_q;

        if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                // The SCL fall right after START arrives with cnt 0 and is ignored.
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (scl_fall && cnt_q == CNT_W'(8)) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            busy_d   = 1'b1;
                            rw_dir_d = shift_q[0];
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise) begin
                        tx_req_d = rw_dir_q;
                    end else if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_dir_q) begin
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == CNT_W'(8)) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b1;
                        state_d  = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RX;
                    end
                end
                // Bit7 was placed at entry; each fall presents the next bit.
                ST_TX: begin
                    if (scl_fall) begin
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + CNT_W'(1);
                        end
                    end
                end
                // A fall here can only follow an ACK; NACK leaves at the rise.
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = ST_IGNORE;
                        end else begin
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        cnt_d    = '0;
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        state_d  = ST_TX;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; sync flops reset to the idle-bus level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_dir_q   <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            rw_dir_q   <= rw_dir_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign rw_dir   = rw_dir_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: a bit-level I2C master drives the bus, a transaction
// model pushes expected bus/host results, and one monitor process scores them.
`timescale 1ns/1ps
module tb_i2c_slave_fsm;

    localparam int         Q        = 8;       // clk cycles per quarter SCL period
    localparam logic [6:0] ADDR     = 7'h55;
    localparam int         K_ACK    = 1;
    localparam int         K_BYTE   = 2;
    localparam int         K_OE9    = 3;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy, rw_dir;
    logic [7:0] rx_data;
    wire        sda_in = ~(m_low | sda_oe);

    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] pay_q[$];
    int         exp_bus_q[$];
    int         obs_q[$];
    chk_t       chk_q[$];

    int   total = 0, bad = 0;
    int   rx_cnt = 0, oe_cnt = 0, txreq_cnt = 0;
    int   m_o, m_e;
    chk_t m_c;
    bit   open_bus = 1'b0;

    i2c_slave_fsm #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl_in  (scl),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy),
        .rw_dir  (rw_dir)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: host model, bus observations and queued checks.
    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_cnt++;
        if (reset_n && rx_valid === 1'b1) begin
            rx_cnt++;
            total++;
            if (exp_rx_q.size() == 0) begin
                bad++;
                $display("FAIL rx_valid_unexpected: got pulse with data %02h, required none", rx_data);
            end else begin
                m_e = int'(exp_rx_q.pop_front());
                if (rx_data !== 8'(m_e)) begin
                    bad++;
                    $display("FAIL rx_data: got %02h required %02h", rx_data, m_e);
                end
            end
        end
        if (reset_n && tx_req === 1'b1) begin
            txreq_cnt++;
            total++;
            if (tx_src_q.size() == 0) begin
                bad++;
                $display("FAIL tx_req_unexpected: got pulse, required none");
            end else begin
                tx_data = tx_src_q.pop_front();
            end
        end
        while (obs_q.size() > 0) begin
            total++;
            m_o = obs_q.pop_front();
            if (exp_bus_q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: got %0h required nothing", m_o);
            end else begin
                m_e = exp_bus_q.pop_front();
                if (m_o != m_e) begin
                    bad++;
                    $display("FAIL bus_kind%0d: got %02h required %02h", m_e >> 8, m_o & 255, m_e & 255);
                end
            end
        end
        while (chk_q.size() > 0) begin
            m_c = chk_q.pop_front();
            total++;
            if (m_c.act !== m_c.exp) begin
                bad++;
                $display("FAIL %s: got %0h required %0h", m_c.name, m_c.act, m_c.exp);
            end
        end
    end

    task automatic req(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit-level master; every bit starts and ends a quarter period after SCL falls.
    task automatic start_cond();
        m_low = 1'b1; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic rep_start();
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b1; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic stop_cond();
        m_low = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b0; tick(2 * Q);
    endtask

    task automatic bit_tx(input logic b, output logic oe_mid);
        m_low = ~b;   tick(Q);
        scl   = 1'b1; tick(Q);
        oe_mid = sda_oe;
        tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic bit_rx(output logic b);
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        b = sda_in;
        tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic x, a;
        for (int i = 7; i >= 0; i--) bit_tx(d[i], x);
        bit_rx(a);
        obs_q.push_back((K_ACK << 8) | int'(a));
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] d;
        logic b, oe9;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_rx(b);
            d = {d[6:0], b};
        end
        bit_tx(nack, oe9);
        obs_q.push_back((K_BYTE << 8) | int'(d));
        obs_q.push_back((K_OE9 << 8) | int'(oe9));
    endtask

    // Transaction model: only the addressed target ACKs, stores write bytes and
    // supplies read bytes; an unaddressed bus reads back as all ones.
    task automatic do_txn(input logic [6:0] addr, input logic rw, input int n, input bit keep);
        logic       match;
        logic [7:0] bytes[$];
        logic [7:0] d;
        match = (addr == ADDR);
        for (int i = 0; i < n; i++) begin
            d = (pay_q.size() > 0) ? pay_q.pop_front() : 8'($urandom);
            bytes.push_back(d);
            if (rw && match) tx_src_q.push_back(d);
        end
        if (open_bus) rep_start(); else start_cond();
        open_bus = 1'b1;
        exp_bus_q.push_back((K_ACK << 8) | (match ? 0 : 1));
        write_byte({addr, rw});
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                exp_bus_q.push_back((K_ACK << 8) | (match ? 0 : 1));
                if (match) exp_rx_q.push_back(bytes[i]);
                write_byte(bytes[i]);
            end else begin
                exp_bus_q.push_back((K_BYTE << 8) | int'(match ? bytes[i] : 8'hFF));
                exp_bus_q.push_back(K_OE9 << 8);
                read_byte(i == n - 1);
            end
        end
        req("busy_in_txn", 32'(busy), 32'(match));
        if (match) req("rw_dir", 32'(rw_dir), 32'(rw));
        if (match && !rw) req("rx_data_held", 32'(rx_data), 32'(bytes[n-1]));
        if (rw) req("oe_after_nack", 32'(sda_oe), 32'd0);
        if (!keep) begin
            stop_cond();
            open_bus = 1'b0;
            req("busy_after_stop", 32'(busy), 32'd0);
            req("oe_after_stop", 32'(sda_oe), 32'd0);
        end
    endtask

    initial begin
        int         r0, o0, t0;
        logic [7:0] a8;
        logic       x, rw;
        logic [6:0] ra;

        // Reset state
        tick(4);
        req("rst_sda_oe", 32'(sda_oe), 32'd0);
        req("rst_rx_data", 32'(rx_data), 32'd0);
        req("rst_rx_valid", 32'(rx_valid), 32'd0);
        req("rst_tx_req", 32'(tx_req), 32'd0);
        req("rst_busy", 32'(busy), 32'd0);
        req("rst_rw_dir", 32'(rw_dir), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Write 0xA5
        r0 = rx_cnt;
        pay_q.push_back(8'hA5);
        do_txn(ADDR, 1'b0, 1, 1'b0);
        tick(2);
        req("write_rx_pulses", 32'(rx_cnt - r0), 32'd1);
        req("write_rx_data", 32'(rx_data), 32'hA5);

        // Address mismatch
        r0 = rx_cnt;
        o0 = oe_cnt;
        pay_q.push_back(8'hFF);
        do_txn(7'h2A, 1'b0, 1, 1'b0);
        tick(2);
        req("mismatch_oe_cycles", 32'(oe_cnt - o0), 32'd0);
        req("mismatch_rx_pulses", 32'(rx_cnt - r0), 32'd0);

        // Read one byte, NACK
        t0 = txreq_cnt;
        pay_q.push_back(8'h3C);
        do_txn(ADDR, 1'b1, 1, 1'b0);
        tick(2);
        req("read1_tx_req_pulses", 32'(txreq_cnt - t0), 32'd1);

        // Read two bytes, ACK then NACK
        t0 = txreq_cnt;
        pay_q.push_back(8'h81);
        pay_q.push_back(8'h7E);
        do_txn(ADDR, 1'b1, 2, 1'b0);
        tick(2);
        req("read2_tx_req_pulses", 32'(txreq_cnt - t0), 32'd2);

        // Write then repeated START into a read
        pay_q.push_back(8'h12);
        do_txn(ADDR, 1'b0, 1, 1'b1);
        do_txn(ADDR, 1'b1, 1, 1'b1);
        req("rs_rx_data", 32'(rx_data), 32'h12);
        req("rs_rw_dir", 32'(rw_dir), 32'd1);
        stop_cond();
        open_bus = 1'b0;
        req("rs_busy_after_stop", 32'(busy), 32'd0);

        // STOP after four data bits
        r0 = rx_cnt;
        start_cond();
        exp_bus_q.push_back(K_ACK << 8);
        write_byte({ADDR, 1'b0});
        for (int i = 0; i < 4; i++) bit_tx(1'($urandom), x);
        stop_cond();
        tick(2);
        req("abort_rx_pulses", 32'(rx_cnt - r0), 32'd0);
        req("abort_busy", 32'(busy), 32'd0);
        do_txn(ADDR, 1'b0, 1, 1'b0);

        // Reset while the address ACK is driven
        start_cond();
        a8 = {ADDR, 1'b0};
        for (int i = 7; i >= 0; i--) bit_tx(a8[i], x);
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q / 2);
        req("ack_oe_before_reset", 32'(sda_oe), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        req("async_rst_sda_oe", 32'(sda_oe), 32'd0);
        req("async_rst_rx_data", 32'(rx_data), 32'd0);
        req("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        req("async_rst_tx_req", 32'(tx_req), 32'd0);
        req("async_rst_busy", 32'(busy), 32'd0);
        req("async_rst_rw_dir", 32'(rw_dir), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(Q / 2);
        scl = 1'b0; tick(Q);
        stop_cond();

        // Randomised transactions
        for (int k = 0; k < 16; k++) begin
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
            if (ra == ADDR && $urandom_range(0, 3) == 0) ra = ra ^ 7'h01;
            do_txn(ra, rw, $urandom_range(1, 3), $urandom_range(0, 3) == 0);
        end
        if (open_bus) begin
            stop_cond();
            open_bus = 1'b0;
        end

        tick(8);
        req("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
        req("tx_queue_drained", 32'(tx_src_q.size()), 32'd0);
        req("bus_queue_drained", 32'(exp_bus_q.size()), 32'd0);
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
